// File: rtl/hilo_muldiv_if.sv
// Operand, opcode and result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Flush;
  logic        HLSel;
  logic        Busy;
  logic [31:0] RHLOut;

  modport master (output A, B, MDOp, Start, Flush, HLSel, input Busy, RHLOut);
  modport slave  (input A, B, MDOp, Start, Flush, HLSel, output Busy, RHLOut);
endinterface

// File: rtl/hilo_muldiv.sv
// MIPS-style HI/LO unit: multi-cycle MULT/MULTU, 32-cycle restoring DIV/DIVU, MTHI/MTLO.
// Define MULDIV_FASTMUL_EN to shorten the multiply phase from 2 cycles to 1.
module hilo_muldiv (
  input  logic          clk,
  input  logic          resetn,
  hilo_muldiv_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MULDIV_FASTMUL_EN
  localparam logic [4:0] MUL_LAST = 5'd0;
`else
  localparam logic [4:0] MUL_LAST = 5'd1;
`endif
  localparam logic [4:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [31:0] hi, lo;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs;

  logic        is_mul, is_div, op_signed;
  logic [31:0] a_mag, b_mag;
  logic [63:0] a_ext, b_ext, prod;
  logic [32:0] shifted;
  logic [31:0] rem_sub, rem_nxt, quo_nxt, q_fix, r_fix;
  logic        take, q_neg, r_neg;

  assign is_mul    = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_MULTU);
  assign is_div    = (bus.MDOp == OP_DIV)  || (bus.MDOp == OP_DIVU);
  assign op_signed = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_DIV);

  // Busy must stall the issuing cycle itself, so it cannot be a registered output.
  assign bus.Busy   = ~bus.Flush &
                      (((state == IDLE) & bus.Start & (is_mul | is_div)) |
                       (state == MUL) | (state == DIV));
  assign bus.RHLOut = bus.HLSel ? hi : lo;

  assign a_mag = (op_signed && bus.A[31]) ? -bus.A : bus.A;
  assign b_mag = (op_signed && bus.B[31]) ? -bus.B : bus.B;

  // Sign- or zero-extend to 64 bits so the low 64 product bits are right for both signednesses.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Restoring step: the remainder always fits 32 bits after the trial subtract.
  assign shifted = {rem, quo[31]};
  assign take    = shifted >= {1'b0, dvs};
  assign rem_sub = shifted[31:0] - dvs;
  assign rem_nxt = take ? rem_sub : shifted[31:0];
  assign quo_nxt = {quo[30:0], take};

  assign q_neg = sgn_q & (a_q[31] ^ b_q[31]);
  assign r_neg = sgn_q & a_q[31];
  assign q_fix = q_neg ? -quo_nxt : quo_nxt;
  assign r_fix = r_neg ? -rem_nxt : rem_nxt;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else if (bus.Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            if (is_mul || is_div) begin
              a_q   <= bus.A;
              b_q   <= bus.B;
              sgn_q <= op_signed;
              cnt   <= '0;
              quo   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              state <= is_mul ? MUL : DIV;
            end else if (bus.MDOp == OP_MTHI) begin
              hi <= bus.A;
            end else if (bus.MDOp == OP_MTLO) begin
              lo <= bus.A;
            end
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            {hi, lo} <= prod;
            state    <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (cnt == DIV_LAST) begin
            if (b_q == '0) begin
              lo <= '1;
              hi <= a_q;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with a scoreboard of expected HI/LO/busy-length per operation.
module tb_hilo_muldiv;

  logic clk;
  logic resetn;
  hilo_muldiv_if bus ();

  hilo_muldiv dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_FASTMUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 3;
`endif
  localparam int DIV_CYC = 33;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hl(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    bus.HLSel = 1'b0;
    #1 check({tag, ".lo"}, bus.RHLOut, elo);
    bus.HLSel = 1'b1;
    #1 check({tag, ".hi"}, bus.RHLOut, ehi);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    bus.Flush = 1'b0;
  endtask

  // Count Busy cycles with Start held and operands scrambled, then compare against the scoreboard.
  task automatic finish_op();
    exp_t e;
    int   cyc = 0;
    #1;
    while (bus.Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
      bus.A = ~bus.A;
      bus.B = bus.B ^ 32'h5a5a_a5a5;
      #1;
    end
    // Still in the DONE cycle with Start high; the next cycle must not be busy.
    @(negedge clk);
    bus.Start = 1'b0;
    bus.MDOp  = OP_NONE;
    #1 check("no_reissue", 32'(bus.Busy), 32'd0);
    e = sb.pop_front();
    check({e.tag, ".busy"}, cyc, e.cycles);
    check_hl(e.tag, e.hi, e.lo);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int ecyc);
    sb.push_back('{tag, ehi, elo, ecyc});
    @(negedge clk);
    issue(op, a, b);
    finish_op();
  endtask

  initial begin
    resetn    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.MDOp  = OP_NONE;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.HLSel = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset.busy", 32'(bus.Busy), 32'd0);
    check_hl("reset", 32'd0, 32'd0);
    resetn = 1'b1;

    do_op("mult_neg",    OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_CYC);
    do_op("multu",       OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, MUL_CYC);
    do_op("mult_minmin", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_CYC);
    do_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC);
    do_op("div_neg",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
    do_op("div_negdvs",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_CYC);
    do_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_CYC);
    do_op("divu_zero",   OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, DIV_CYC);
    do_op("div_zero",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYC);
    do_op("divu_big",    OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, DIV_CYC);

    // DIVU flushed ten cycles in: no write, and a MULT is accepted the following cycle.
    @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    bus.Flush = 1'b1;
    #1 check("flush.busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    sb.push_back('{"post_flush_mult", 32'h0000_0000, 32'h0000_002A, MUL_CYC});
    issue(OP_MULT, 32'd6, 32'd7);
    #1 check("post_flush.accept", 32'(bus.Busy), 32'd1);
    check_hl("flush_nowrite", 32'h0000_000F, 32'h0FFF_FFFF);
    finish_op();

    // MTHI/MTLO write without stalling; a flushed MTHI is dropped.
    @(negedge clk);
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    #1 check("mthi.busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    bus.HLSel = 1'b1;
    #1 check("mthi.read", bus.RHLOut, 32'h1234_5678);
    @(negedge clk);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    check_hl("mt_flushed", 32'h1234_5678, 32'hCAFE_F00D);

    // Reset in the middle of a divide, with Start still asserted.
    @(negedge clk);
    issue(OP_DIV, 32'd50, 32'd3);
    repeat (5) @(negedge clk);
    #1 check("middiv.busy", 32'(bus.Busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn    = 1'b1;
    bus.Start = 1'b0;
    #1 check("middiv_reset.busy", 32'(bus.Busy), 32'd0);
    check_hl("middiv_reset", 32'd0, 32'd0);

    do_op("after_reset", OP_MULTU, 32'd50, 32'd3, 32'd0, 32'd150, MUL_CYC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, reset synchronous and active-low.
REQ-003 SHALL have ports A and B, input, 32 each, EX-stage operands: A is the rs value or dividend, B is the rt value or divisor.
REQ-004 SHALL have port MDOp, input, 3, opcode: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-005 SHALL have port Start, input, 1, instruction in EX is valid and carries MDOp.
REQ-006 SHALL have port Flush, input, 1, exception or cancel of the EX instruction.
REQ-007 SHALL have port HLSel, input, 1, read select: 0 LO, 1 HI.
REQ-008 SHALL have port Busy, output, 1, pipeline stall request.
REQ-009 SHALL have port RHLOut, output, 32, HLSel ? HI : LO, combinational from the registers.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-011 IDLE with Start, no Flush, MDOp in {MULT, MULTU}: SHALL latch A/B, go to MUL, clear the counter.
REQ-012 IDLE with Start, no Flush, MDOp in {DIV, DIVU}: SHALL latch A/B, go to DIV, clear the counter.
REQ-013 IDLE with Start, no Flush, MTHI/MTLO: SHALL write A to HI/LO at that edge; stay IDLE; no Busy.
REQ-014 Busy SHALL be high when (IDLE & Start & ~Flush & MDOp is MULT, MULTU, DIV or DIVU), in MUL, and in DIV; low in IDLE otherwise and in DONE.
REQ-015 MUL SHALL last 2 cycles, then write the 64-bit product {HI,LO} and go to DONE.
REQ-016 MULT issued in cycle T SHALL give Busy high in T, T+1, T+2, HI/LO updated at the end of T+2, and DONE in T+3.
REQ-017 MULT SHALL treat operands as two's complement; MULTU SHALL treat them as unsigned.
REQ-018 DIV SHALL use a radix-2 restoring iteration on operand magnitudes, 1 bit per cycle for 32 cycles, then write LO=quotient and HI=remainder and go to DONE.
REQ-019 A divide issued in cycle T SHALL give Busy for 33 cycles (T..T+32) and DONE in T+33.
REQ-020 Signed DIV: quotient sign SHALL be A[31]^B[31]; remainder sign SHALL be A[31] (truncating division).
REQ-021 Divisor 0, either signedness: SHALL write LO=0xFFFFFFFF and HI=A with no sign fixup.
REQ-022 DONE SHALL last one cycle with Busy low, return to IDLE, and ignore Start (the same instruction is still presented).
REQ-023 Flush in any state SHALL force IDLE next edge, with Busy low in the Flush cycle, no HI/LO write, and MTHI/MTLO suppressed.
REQ-024 A result write and an MTHI/MTLO SHALL never coincide, since MTHI/MTLO is accepted only in IDLE.
REQ-025 Start while in MUL/DIV SHALL be ignored; operands SHALL use only the values latched at acceptance.

Reset
REQ-026 resetn low at an edge SHALL set HI=0, LO=0, state IDLE and counter 0, so Busy=0 and RHLOut=0.
REQ-027 Reset mid-MUL/DIV SHALL abandon the operation with no partial HI/LO write.
REQ-028 Reset SHALL take priority over Flush and Start.

Configuration
REQ-029 With macro MULDIV_FASTMUL_EN defined, MUL SHALL last 1 cycle: MULT at T gives Busy in T, T+1, a write at the end of T+1, and DONE in T+2.
REQ-030 Without MULDIV_FASTMUL_EN, MUL SHALL last 2 cycles per REQ-015/016; divide timing is unaffected either way.

Verification
REQ-031 MULT A=0xFFFFFFFE, B=0x00000003 -> Busy 3 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA (2 cycles with MULDIV_FASTMUL_EN).
REQ-032 MULTU A=0xFFFFFFFE, B=0x00000003 -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 DIV A=0xFFFFFFF9, B=0x00000002 -> Busy 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-034 DIVU started at T with Flush at T+10 -> Busy low at T+10; HI/LO unchanged; new MULT accepted at T+11.
REQ-035 Start held high through DONE -> no second operation; HI/LO written exactly once.
REQ-036 MTHI A=0x12345678, then HLSel=1 next cycle -> RHLOut=0x12345678; resetn low mid-DIV -> HI=LO=0, Busy=0 the next cycle.
